// File: rtl/otter_phys_regfile_if.sv
// Bus bundle between rename/issue/writeback and the physical register file.
// The owning side (rename, issue, writeback) uses the master modport; the register file uses slave.
interface otter_phys_regfile_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_PREGS = 64,
  parameter int unsigned NUM_RD    = 4,
  parameter int unsigned NUM_WR    = 2,
  parameter int unsigned NUM_ALLOC = 1
);
  localparam int unsigned PW = $clog2(NUM_PREGS);

  logic [NUM_RD*PW-1:0]    rd_addr;
  logic [NUM_RD*XLEN-1:0]  rd_data;
  logic [NUM_RD-1:0]       rd_ready;
  logic [NUM_WR-1:0]       wr_en;
  logic [NUM_WR*PW-1:0]    wr_addr;
  logic [NUM_WR*XLEN-1:0]  wr_data;
  logic [NUM_ALLOC-1:0]    alloc_en;
  logic [NUM_ALLOC*PW-1:0] alloc_addr;
  logic                    flush;
  logic [PW:0]             busy_count;
  logic                    wr_conflict;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    input  rd_data, rd_ready, busy_count, wr_conflict
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    output rd_data, rd_ready, busy_count, wr_conflict
  );
endinterface

// File: rtl/otter_phys_regfile.sv
// Physical register file with per-preg ready scoreboard, write-first bypass,
// rename-side allocation and flush-to-ready recovery. Preg 0 is hard-wired zero.
module otter_phys_regfile #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_PREGS = 64,
  parameter int unsigned NUM_RD    = 4,
  parameter int unsigned NUM_WR    = 2,
  parameter int unsigned NUM_ALLOC = 1
) (
  input logic                clock,
  input logic                reset,
  otter_phys_regfile_if.slave rf
);
  localparam int unsigned PW = $clog2(NUM_PREGS);

  logic [XLEN-1:0]      regs [NUM_PREGS];
  logic [NUM_PREGS-1:0] ready;
  logic [NUM_PREGS-1:0] ready_nxt;
  logic [PW:0]          busy_nxt;
  logic                 conflict_nxt;
  logic [NUM_RD*XLEN-1:0] rd_data_c;
  logic [NUM_RD-1:0]      rd_ready_c;

  // Combinational read with write-first bypass; later write ports override earlier ones.
  always_comb begin
    logic [PW-1:0] ra;
    rd_data_c  = '0;
    rd_ready_c = '1;
    ra         = '0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      ra = rf.rd_addr[i*PW +: PW];
      if (ra != '0) begin
        rd_data_c[i*XLEN +: XLEN] = regs[ra];
        rd_ready_c[i]             = ready[ra];
        for (int j = 0; j < int'(NUM_WR); j++) begin
          if (rf.wr_en[j] && (rf.wr_addr[j*PW +: PW] == ra)) begin
            rd_data_c[i*XLEN +: XLEN] = rf.wr_data[j*XLEN +: XLEN];
            rd_ready_c[i]             = 1'b1;
          end
        end
      end
    end
  end

  assign rf.rd_data  = rd_data_c;
  assign rf.rd_ready = rd_ready_c;

  // Next ready vector: writes set, allocs clear (alloc wins), flush sets everything.
  always_comb begin
    ready_nxt = ready;
    for (int j = 0; j < int'(NUM_WR); j++) begin
      if (rf.wr_en[j] && (rf.wr_addr[j*PW +: PW] != '0))
        ready_nxt[rf.wr_addr[j*PW +: PW]] = 1'b1;
    end
    for (int k = 0; k < int'(NUM_ALLOC); k++) begin
      if (rf.alloc_en[k] && (rf.alloc_addr[k*PW +: PW] != '0))
        ready_nxt[rf.alloc_addr[k*PW +: PW]] = 1'b0;
    end
    if (rf.flush)
      ready_nxt = '1;
    ready_nxt[0] = 1'b1;
  end

  always_comb begin
    busy_nxt = '0;
    for (int i = 0; i < int'(NUM_PREGS); i++) begin
      if (!ready_nxt[i])
        busy_nxt = busy_nxt + (PW+1)'(1);
    end
  end

  always_comb begin
    conflict_nxt = 1'b0;
    for (int a = 0; a < int'(NUM_WR); a++) begin
      for (int b = a + 1; b < int'(NUM_WR); b++) begin
        if (rf.wr_en[a] && rf.wr_en[b] &&
            (rf.wr_addr[a*PW +: PW] == rf.wr_addr[b*PW +: PW]) &&
            (rf.wr_addr[a*PW +: PW] != '0))
          conflict_nxt = 1'b1;
      end
    end
  end

  // State update; ascending port order lets the highest write port win on collisions.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_PREGS); i++)
        regs[i] <= '0;
      ready          <= '1;
      rf.busy_count  <= '0;
      rf.wr_conflict <= 1'b0;
    end else begin
      for (int j = 0; j < int'(NUM_WR); j++) begin
        if (rf.wr_en[j] && (rf.wr_addr[j*PW +: PW] != '0))
          regs[rf.wr_addr[j*PW +: PW]] <= rf.wr_data[j*XLEN +: XLEN];
      end
      ready          <= ready_nxt;
      rf.busy_count  <= busy_nxt;
      rf.wr_conflict <= conflict_nxt;
    end
  end
endmodule
